guess_ctrl: RTL and testbench
=============================

# guess_ctrl

Parametrised game controller for the number-guessing datapath, replacing the fixed 8-bit three-state control unit. It holds a secret value and a live `[lo_bound, hi_bound]` window, and judges each guess presented on a valid strobe. For each judged guess it returns a registered hint (too low, too high, out of range), then narrows the window. It also counts attempts and ends the game in WIN or LOSE. It sits between the guess-entry front end and the display/status logic.

## Interface
- `W`, 8: width of secret, guesses and bounds.
- `MAX_TRIES`, 7: in-range wrong guesses allowed before LOSE; legal range 1..2^TRY_W-1.
- `TRY_W`, 4: width of the attempt counter.

- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: synchronous active-high reset.
- `start` in 1: load a new game from `secret_in`/`lo_init`/`hi_init`; accepted in any state.
- `secret_in` in W: secret value, sampled with `start`.
- `lo_init` in W: initial low bound, sampled with `start`.
- `hi_init` in W: initial high bound, sampled with `start`.
- `guess_valid` in 1: one-cycle strobe qualifying `guess`.
- `guess` in W: player guess.
- `rsp_valid` out 1: one-cycle pulse; hint flags below are valid.
- `too_low` out 1: guess < secret (with `rsp_valid`).
- `too_high` out 1: guess > secret (with `rsp_valid`).
- `outrange` out 1: guess outside the current window (with `rsp_valid`).
- `done` out 1: game won; level, held in WIN.
- `lose` out 1: attempts exhausted; level, held in LOSE.
- `busy` out 1: high in PLAY.
- `cfg_err` out 1: one-cycle pulse; rejected `start`.
- `tries` out TRY_W: in-range guesses consumed this game.
- `lo_bound` out W: current window low edge.
- `hi_bound` out W: current window high edge.

## Operation
- **States.** IDLE, PLAY, WIN, LOSE.
- **Priority.** `rst` > `start` > `guess_valid`.
- **Start validation.** `start` is legal iff `lo_init <= secret_in <= hi_init`.
  - If illegal: pulse `cfg_err` and go to IDLE. Secret and bounds are unchanged.
  - If legal: latch secret, set `lo_bound = lo_init`, `hi_bound = hi_init`, `tries = 0`, clear `done`/`lose`, and go to PLAY.
  - This applies from any state, including aborting a game in PLAY.
- **Guess outside the window** (PLAY, `guess_valid`, `guess < lo_bound` or `guess > hi_bound`):
  - `outrange=1`.
  - `tries`, bounds and state are unchanged; it does not count as an attempt.
- **Guess inside the window:** `tries <= tries+1`, then exactly one of:
  - `guess == secret`: go to WIN, `done=1`, no hint flag.
  - `guess < secret`: `too_low=1`, `lo_bound <= guess+1`.
  - `guess > secret`: `too_high=1`, `hi_bound <= guess-1`.
- **LOSE condition.** A wrong in-range guess that makes `tries == MAX_TRIES` goes to LOSE with `lose=1`. The hint for that guess is still reported.
- **Arithmetic is overflow-free by construction.**
  - `guess+1` only occurs when guess < secret ≤ 2^W-1.
  - `guess-1` only occurs when guess > secret ≥ 0.
  - No saturation logic is needed.
- **Ignored strobes.** `guess_valid` in IDLE, WIN or LOSE is ignored: no `rsp_valid` and no state change.
- **WIN/LOSE** hold until `start` or `rst`.

## Timing
- **Reset values:**
  - state IDLE.
  - all flags 0: `rsp_valid`, `too_low`, `too_high`, `outrange`, `done`, `lose`, `busy`, `cfg_err`.
  - `tries=0`, `lo_bound=0`, `hi_bound=2^W-1`, secret 0.
- **Response latency.** All outputs are registered. Guess sampled on edge N → `rsp_valid` plus hint flags high for the cycle after edge N. Updated bounds, `tries`, and `done`/`lose` are visible from the same edge.
- **Throughput.** Back-to-back `guess_valid` every cycle is legal. Each guess is judged against the bounds already updated by the previous guess, so no bubble is needed.
- **Start latency.** `start` on edge N → `busy=1` (or `cfg_err` pulse) after edge N.
- **Simultaneous start and guess.** `start` with `guess_valid` in the same cycle: the guess is dropped and no `rsp_valid` is produced.
- **Reset mid-game.** `rst` mid-game returns everything to reset values on the next edge. An in-flight response is not emitted.
- **Pulse widths.** `rsp_valid` and `cfg_err` are exactly one cycle wide.

## Test plan
1. **Win in three guesses.** `start` with secret=42, lo=0, hi=100; guesses 50, 25, 42 → required responses:
   - too_high, hi_bound=49, tries=1.
   - too_low, lo_bound=26, tries=2.
   - rsp_valid, done=1, busy=0, tries=3.
2. **Out-of-range guesses.** With window [26,49], guess 60, then 10 → outrange=1 both times; tries, bounds and state unchanged.
3. **Lose after MAX_TRIES.** secret=99, lo=0, hi=255, MAX_TRIES=7; guesses 0,1,2,3,4,5,6 → seventh response is too_low with lose=1. A following guess 99 produces no rsp_valid.
4. **Boundary values.**
   - secret=255, window [0,255]: guess 254 → lo_bound=255; guess 255 → done.
   - secret=0: guess 1 → hi_bound=0; guess 0 → done.
5. **Illegal start and simultaneous start/guess.**
   - `start` with secret=200, lo=0, hi=100 → cfg_err pulse, state stays IDLE, busy=0.
   - `start` plus `guess_valid` in the same cycle during PLAY → restart, no rsp_valid.
6. **Reset mid-game.** Assert `rst` after two guesses in PLAY → next cycle all outputs at reset values; `guess_valid` is ignored until a new `start`.

Source files
------------

// File: rtl/guess_ctrl_if.sv
// Bundle between the guess-entry front end (master) and the game controller (slave).
// Carries game setup, guess strobes, registered hints and live game status.
interface guess_ctrl_if #(
  parameter int W     = 8,
  parameter int TRY_W = 4
);
  logic             start;
  logic [W-1:0]     secret_in;
  logic [W-1:0]     lo_init;
  logic [W-1:0]     hi_init;
  logic             guess_valid;
  logic [W-1:0]     guess;
  logic             rsp_valid;
  logic             too_low;
  logic             too_high;
  logic             outrange;
  logic             done;
  logic             lose;
  logic             busy;
  logic             cfg_err;
  logic [TRY_W-1:0] tries;
  logic [W-1:0]     lo_bound;
  logic [W-1:0]     hi_bound;

  modport master (
    output start, secret_in, lo_init, hi_init, guess_valid, guess,
    input  rsp_valid, too_low, too_high, outrange, done, lose, busy, cfg_err,
           tries, lo_bound, hi_bound
  );

  modport slave (
    input  start, secret_in, lo_init, hi_init, guess_valid, guess,
    output rsp_valid, too_low, too_high, outrange, done, lose, busy, cfg_err,
           tries, lo_bound, hi_bound
  );
endinterface

// File: rtl/guess_ctrl.sv
// Number-guessing game controller: holds the secret and a shrinking [lo,hi] window,
// judges each guess with a registered hint one cycle later, and tracks WIN/LOSE.
module guess_ctrl #(
  parameter int W         = 8,
  parameter int MAX_TRIES = 7,
  parameter int TRY_W     = 4
) (
  input  logic         clk,
  input  logic         rst,
  guess_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, PLAY, WIN, LOSE} state_t;

  state_t           state, state_nxt;
  logic [W-1:0]     secret_p1, secret_nxt;
  logic [W-1:0]     lo_p1, lo_nxt;
  logic [W-1:0]     hi_p1, hi_nxt;
  logic [TRY_W-1:0] tries_p1, tries_nxt, tries_inc;
  logic             vld_p1, vld_nxt;
  logic             too_low_p1, too_low_nxt;
  logic             too_high_p1, too_high_nxt;
  logic             outrange_p1, outrange_nxt;
  logic             cfg_err_p1, cfg_err_nxt;

  logic start_ok, judge, in_win, hit, last_try;

  // start has priority, so a guess presented alongside it is never judged
  assign start_ok  = (bus.lo_init <= bus.secret_in) && (bus.secret_in <= bus.hi_init);
  assign judge     = (state == PLAY) && bus.guess_valid && !bus.start;
  assign in_win    = (bus.guess >= lo_p1) && (bus.guess <= hi_p1);
  assign hit       = (bus.guess == secret_p1);
  assign tries_inc = tries_p1 + TRY_W'(1);
  assign last_try  = (tries_inc == TRY_W'(MAX_TRIES));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.start) begin
      state_nxt = start_ok ? PLAY : IDLE;
    end else if (judge && in_win) begin
      if (hit)           state_nxt = WIN;
      else if (last_try) state_nxt = LOSE;
    end
  end

  // guess+1 / guess-1 cannot wrap: they only occur strictly below / above the secret
  always_comb begin
    secret_nxt   = secret_p1;
    lo_nxt       = lo_p1;
    hi_nxt       = hi_p1;
    tries_nxt    = tries_p1;
    vld_nxt      = 1'b0;
    too_low_nxt  = 1'b0;
    too_high_nxt = 1'b0;
    outrange_nxt = 1'b0;
    cfg_err_nxt  = 1'b0;
    if (bus.start) begin
      if (start_ok) begin
        secret_nxt = bus.secret_in;
        lo_nxt     = bus.lo_init;
        hi_nxt     = bus.hi_init;
        tries_nxt  = '0;
      end else begin
        cfg_err_nxt = 1'b1;
      end
    end else if (judge) begin
      vld_nxt = 1'b1;
      if (!in_win) begin
        outrange_nxt = 1'b1;
      end else begin
        tries_nxt = tries_inc;
        if (!hit) begin
          if (bus.guess < secret_p1) begin
            too_low_nxt = 1'b1;
            lo_nxt      = bus.guess + W'(1);
          end else begin
            too_high_nxt = 1'b1;
            hi_nxt       = bus.guess - W'(1);
          end
        end
      end
    end
  end

  // ---- stage p1: registered hints, window and attempt count ----
  always_ff @(posedge clk) begin
    if (rst) begin
      secret_p1   <= '0;
      lo_p1       <= '0;
      hi_p1       <= '1;
      tries_p1    <= '0;
      vld_p1      <= 1'b0;
      too_low_p1  <= 1'b0;
      too_high_p1 <= 1'b0;
      outrange_p1 <= 1'b0;
      cfg_err_p1  <= 1'b0;
    end else begin
      secret_p1   <= secret_nxt;
      lo_p1       <= lo_nxt;
      hi_p1       <= hi_nxt;
      tries_p1    <= tries_nxt;
      vld_p1      <= vld_nxt;
      too_low_p1  <= too_low_nxt;
      too_high_p1 <= too_high_nxt;
      outrange_p1 <= outrange_nxt;
      cfg_err_p1  <= cfg_err_nxt;
    end
  end

  assign bus.rsp_valid = vld_p1;
  assign bus.too_low   = too_low_p1;
  assign bus.too_high  = too_high_p1;
  assign bus.outrange  = outrange_p1;
  assign bus.cfg_err   = cfg_err_p1;
  assign bus.tries     = tries_p1;
  assign bus.lo_bound  = lo_p1;
  assign bus.hi_bound  = hi_p1;
  assign bus.busy      = (state == PLAY);
  assign bus.done      = (state == WIN);
  assign bus.lose      = (state == LOSE);

endmodule

// File: tb/tb_guess_ctrl.sv
// Scenario bench for guess_ctrl: a reference game model pushes expected responses,
// a negedge monitor pops and compares them; each scenario also checks known constants.
module tb_guess_ctrl;
  localparam int W = 8;
  localparam int MAX_TRIES = 7;
  localparam int TRY_W = 4;
  localparam int ST_IDLE = 0, ST_PLAY = 1, ST_WIN = 2, ST_LOSE = 3;

  typedef struct {
    int         due;
    logic       v, tl, th, orr, dn, ls, by;
    logic [3:0] tr;
    logic [7:0] lo, hi;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q[$];

  int         m_st = ST_IDLE;
  logic [7:0] m_secret = 8'd0, m_lo = 8'd0, m_hi = 8'd255;
  logic [3:0] m_tries = 4'd0;

  guess_ctrl_if #(.W(W), .TRY_W(TRY_W)) b();

  guess_ctrl #(.W(W), .MAX_TRIES(MAX_TRIES), .TRY_W(TRY_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard: every rsp_valid must match the oldest expectation due this cycle
  always @(negedge clk) begin
    if (q.size() > 0 && q[0].due == cyc) begin
      exp_t e;
      e = q.pop_front();
      n_cmp++;
      if ({b.rsp_valid, b.too_low, b.too_high, b.outrange, b.done, b.lose, b.busy,
           b.tries, b.lo_bound, b.hi_bound} !==
          {e.v, e.tl, e.th, e.orr, e.dn, e.ls, e.by, e.tr, e.lo, e.hi}) begin
        n_bad++;
        $display("FAIL rsp@%0d: got v%b tl%b th%b or%b dn%b ls%b by%b tr=%0d lo=%0d hi=%0d, need v%b tl%b th%b or%b dn%b ls%b by%b tr=%0d lo=%0d hi=%0d",
                 cyc, b.rsp_valid, b.too_low, b.too_high, b.outrange, b.done, b.lose, b.busy,
                 b.tries, b.lo_bound, b.hi_bound,
                 e.v, e.tl, e.th, e.orr, e.dn, e.ls, e.by, e.tr, e.lo, e.hi);
      end
    end else if (b.rsp_valid === 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_rsp@%0d: got rsp_valid=1 need 0", cyc);
    end
  end

  task automatic model_reset();
    m_st = ST_IDLE; m_secret = 8'd0; m_lo = 8'd0; m_hi = 8'd255; m_tries = 4'd0;
  endtask

  // entered and left at posedge+1
  task automatic do_start(input logic [7:0] s, input logic [7:0] lo, input logic [7:0] hi,
                          input logic gv, input logic [7:0] g);
    b.start = 1'b1; b.secret_in = s; b.lo_init = lo; b.hi_init = hi;
    b.guess_valid = gv; b.guess = g;
    if (lo <= s && s <= hi) begin
      m_st = ST_PLAY; m_secret = s; m_lo = lo; m_hi = hi; m_tries = 4'd0;
    end else begin
      m_st = ST_IDLE;
    end
    @(posedge clk); #1;
    b.start = 1'b0; b.guess_valid = 1'b0;
  endtask

  task automatic do_guess(input logic [7:0] g);
    exp_t e;
    b.guess_valid = 1'b1; b.guess = g;
    if (m_st == ST_PLAY) begin
      e.due = cyc + 1; e.v = 1'b1; e.tl = 1'b0; e.th = 1'b0; e.orr = 1'b0;
      if (g < m_lo || g > m_hi) begin
        e.orr = 1'b1;
      end else begin
        m_tries++;
        if (g == m_secret) begin
          m_st = ST_WIN;
        end else begin
          if (g < m_secret) begin e.tl = 1'b1; m_lo = g + 8'd1; end
          else              begin e.th = 1'b1; m_hi = g - 8'd1; end
          if (m_tries == MAX_TRIES) m_st = ST_LOSE;
        end
      end
      e.dn = (m_st == ST_WIN); e.ls = (m_st == ST_LOSE); e.by = (m_st == ST_PLAY);
      e.tr = m_tries; e.lo = m_lo; e.hi = m_hi;
      q.push_back(e);
    end
    @(posedge clk); #1;
    b.guess_valid = 1'b0;
  endtask

  task automatic test_reset();
    b.start = 0; b.secret_in = 0; b.lo_init = 0; b.hi_init = 0; b.guess_valid = 0; b.guess = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    n_cmp++;
    if ({b.rsp_valid, b.too_low, b.too_high, b.outrange, b.done, b.lose, b.busy, b.cfg_err,
         b.tries, b.lo_bound, b.hi_bound} !== {8'b0, 4'd0, 8'd0, 8'd255}) begin
      n_bad++;
      $display("FAIL reset_vals: got flags=%b tries=%0d lo=%0d hi=%0d need flags=00000000 tries=0 lo=0 hi=255",
               {b.rsp_valid, b.too_low, b.too_high, b.outrange, b.done, b.lose, b.busy, b.cfg_err},
               b.tries, b.lo_bound, b.hi_bound);
    end
  endtask

  task automatic test_win();
    do_start(8'd42, 8'd0, 8'd100, 1'b0, 8'd0);
    n_cmp++;
    if ({b.busy, b.cfg_err, b.tries} !== {2'b10, 4'd0}) begin
      n_bad++; $display("FAIL win_start: got busy=%b cfg_err=%b tries=%0d need 1 0 0", b.busy, b.cfg_err, b.tries);
    end
    do_guess(8'd50);
    n_cmp++;
    if ({b.rsp_valid, b.too_high, b.hi_bound, b.tries} !== {2'b11, 8'd49, 4'd1}) begin
      n_bad++; $display("FAIL win_g50: got v=%b th=%b hi=%0d tr=%0d need 1 1 49 1", b.rsp_valid, b.too_high, b.hi_bound, b.tries);
    end
    do_guess(8'd25);
    n_cmp++;
    if ({b.rsp_valid, b.too_low, b.lo_bound, b.tries} !== {2'b11, 8'd26, 4'd2}) begin
      n_bad++; $display("FAIL win_g25: got v=%b tl=%b lo=%0d tr=%0d need 1 1 26 2", b.rsp_valid, b.too_low, b.lo_bound, b.tries);
    end
  endtask

  task automatic test_outrange();
    do_guess(8'd60);
    n_cmp++;
    if ({b.rsp_valid, b.outrange, b.busy, b.tries, b.lo_bound, b.hi_bound} !== {3'b111, 4'd2, 8'd26, 8'd49}) begin
      n_bad++; $display("FAIL outr_g60: got v=%b or=%b by=%b tr=%0d lo=%0d hi=%0d need 1 1 1 2 26 49",
                        b.rsp_valid, b.outrange, b.busy, b.tries, b.lo_bound, b.hi_bound);
    end
    do_guess(8'd10);
    n_cmp++;
    if ({b.rsp_valid, b.outrange, b.busy, b.tries, b.lo_bound, b.hi_bound} !== {3'b111, 4'd2, 8'd26, 8'd49}) begin
      n_bad++; $display("FAIL outr_g10: got v=%b or=%b by=%b tr=%0d lo=%0d hi=%0d need 1 1 1 2 26 49",
                        b.rsp_valid, b.outrange, b.busy, b.tries, b.lo_bound, b.hi_bound);
    end
    do_guess(8'd42);
    n_cmp++;
    if ({b.rsp_valid, b.done, b.busy, b.tries} !== {3'b110, 4'd3}) begin
      n_bad++; $display("FAIL win_g42: got v=%b dn=%b by=%b tr=%0d need 1 1 0 3", b.rsp_valid, b.done, b.busy, b.tries);
    end
  endtask

  task automatic test_lose();
    do_start(8'd99, 8'd0, 8'd255, 1'b0, 8'd0);
    for (int i = 0; i < 7; i++) do_guess(8'(i));
    n_cmp++;
    if ({b.rsp_valid, b.too_low, b.lose, b.busy, b.tries} !== {4'b1110, 4'd7}) begin
      n_bad++; $display("FAIL lose_7th: got v=%b tl=%b ls=%b by=%b tr=%0d need 1 1 1 0 7", b.rsp_valid, b.too_low, b.lose, b.busy, b.tries);
    end
    do_guess(8'd99);
    n_cmp++;
    if ({b.rsp_valid, b.lose, b.done, b.tries} !== {3'b010, 4'd7}) begin
      n_bad++; $display("FAIL lose_hold: got v=%b ls=%b dn=%b tr=%0d need 0 1 0 7", b.rsp_valid, b.lose, b.done, b.tries);
    end
  endtask

  task automatic test_boundary();
    do_start(8'd255, 8'd0, 8'd255, 1'b0, 8'd0);
    do_guess(8'd254);
    n_cmp++;
    if ({b.too_low, b.lo_bound, b.hi_bound} !== {1'b1, 8'd255, 8'd255}) begin
      n_bad++; $display("FAIL bnd_hi_lo: got tl=%b lo=%0d hi=%0d need 1 255 255", b.too_low, b.lo_bound, b.hi_bound);
    end
    do_guess(8'd255);
    n_cmp++;
    if ({b.rsp_valid, b.done} !== 2'b11) begin
      n_bad++; $display("FAIL bnd_hi_win: got v=%b dn=%b need 1 1", b.rsp_valid, b.done);
    end
    do_start(8'd0, 8'd0, 8'd255, 1'b0, 8'd0);
    do_guess(8'd1);
    n_cmp++;
    if ({b.too_high, b.lo_bound, b.hi_bound} !== {1'b1, 8'd0, 8'd0}) begin
      n_bad++; $display("FAIL bnd_lo_hi: got th=%b lo=%0d hi=%0d need 1 0 0", b.too_high, b.lo_bound, b.hi_bound);
    end
    do_guess(8'd0);
    n_cmp++;
    if ({b.rsp_valid, b.done, b.tries} !== {2'b11, 4'd2}) begin
      n_bad++; $display("FAIL bnd_lo_win: got v=%b dn=%b tr=%0d need 1 1 2", b.rsp_valid, b.done, b.tries);
    end
  endtask

  task automatic test_illegal_start();
    do_start(8'd200, 8'd0, 8'd100, 1'b0, 8'd0);
    n_cmp++;
    if ({b.cfg_err, b.busy, b.done, b.lo_bound, b.hi_bound} !== {3'b100, 8'd0, 8'd0}) begin
      n_bad++; $display("FAIL bad_start: got ce=%b by=%b dn=%b lo=%0d hi=%0d need 1 0 0 0 0",
                        b.cfg_err, b.busy, b.done, b.lo_bound, b.hi_bound);
    end
    do_guess(8'd0);
    n_cmp++;
    if ({b.cfg_err, b.rsp_valid, b.busy} !== 3'b000) begin
      n_bad++; $display("FAIL idle_ignore: got ce=%b v=%b by=%b need 0 0 0", b.cfg_err, b.rsp_valid, b.busy);
    end
  endtask

  task automatic test_start_with_guess();
    do_start(8'd42, 8'd0, 8'd100, 1'b0, 8'd0);
    do_guess(8'd50);
    do_start(8'd30, 8'd10, 8'd60, 1'b1, 8'd10);
    n_cmp++;
    if ({b.rsp_valid, b.busy, b.tries, b.lo_bound, b.hi_bound} !== {2'b01, 4'd0, 8'd10, 8'd60}) begin
      n_bad++; $display("FAIL start_guess: got v=%b by=%b tr=%0d lo=%0d hi=%0d need 0 1 0 10 60",
                        b.rsp_valid, b.busy, b.tries, b.lo_bound, b.hi_bound);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq [6] = '{8'd200, 8'd100, 8'd7, 8'd150, 8'd120, 8'd128};
    do_start(8'd128, 8'd0, 8'd255, 1'b0, 8'd0);
    foreach (seq[i]) do_guess(seq[i]);
    n_cmp++;
    if ({b.done, b.tries, b.lo_bound, b.hi_bound} !== {1'b1, 4'd5, 8'd121, 8'd149}) begin
      n_bad++; $display("FAIL b2b_end: got dn=%b tr=%0d lo=%0d hi=%0d need 1 5 121 149", b.done, b.tries, b.lo_bound, b.hi_bound);
    end
  endtask

  task automatic test_reset_mid();
    do_start(8'd42, 8'd0, 8'd100, 1'b0, 8'd0);
    do_guess(8'd50);
    do_guess(8'd25);
    rst = 1'b1; b.guess_valid = 1'b1; b.guess = 8'd42;
    @(posedge clk); #1;
    rst = 1'b0; b.guess_valid = 1'b0;
    model_reset();
    n_cmp++;
    if ({b.rsp_valid, b.too_low, b.too_high, b.outrange, b.done, b.lose, b.busy, b.cfg_err,
         b.tries, b.lo_bound, b.hi_bound} !== {8'b0, 4'd0, 8'd0, 8'd255}) begin
      n_bad++; $display("FAIL rst_mid: got flags=%b tr=%0d lo=%0d hi=%0d need 00000000 0 0 255",
                        {b.rsp_valid, b.too_low, b.too_high, b.outrange, b.done, b.lose, b.busy, b.cfg_err},
                        b.tries, b.lo_bound, b.hi_bound);
    end
    do_guess(8'd42);
    n_cmp++;
    if ({b.rsp_valid, b.done, b.busy, b.tries} !== {3'b000, 4'd0}) begin
      n_bad++; $display("FAIL rst_ignore: got v=%b dn=%b by=%b tr=%0d need 0 0 0 0", b.rsp_valid, b.done, b.busy, b.tries);
    end
  endtask

  initial begin
    test_reset();
    test_win();
    test_outrange();
    test_lose();
    test_boundary();
    test_illegal_start();
    test_start_with_guess();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++; $display("FAIL drain: got %0d pending responses need 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
